// File: rtl/ms_video_timing_gen.sv
// ms_video_timing_gen
//   Parametrised raster timing generator for the VDP. It counts native pixel
//   clocks and lines, then derives logical (pixel/line repeated) hpos/vpos,
//   sync, blank, border, the renderer line lookahead, and line/vblank IRQ
//   pulses. Every output is registered and lags the counters by one clock.
//
//   Optional feature macro: VDP_HLATCH_EN
//     defined   : i_hlatch_strobe is synchronised, edge detected, and latches hpos
//     undefined : i_hlatch_strobe is ignored, o_hlatch_value is tied to 0
//
// Ports
//   i_clk               video pixel clock
//   i_reset             synchronous, active-high reset
//   i_left_col_blank    widen the left border by LEFT_COL_W logical pixels
//   i_irq_line[7:0]     logical line that raises o_line_irq_pulse
//   i_hlatch_strobe     H-counter latch request (async)
//   o_hpos[7:0]         logical x inside the active area, 0 outside
//   o_vpos[7:0]         logical y relative to the active top, mod 256
//   o_hlatch_value[7:0] hpos captured on a latch request
//   o_render_line[7:0]  vpos + RENDER_LEAD for the next line
//   o_render_start      1-clk pulse, renderer begins o_render_line
//   o_next_line         1-clk pulse on the last clock of a logical line
//   o_line_irq_pulse    1-clk pulse, next_line with vpos == i_irq_line
//   o_vblank_irq_pulse  1-clk pulse, next_line with vpos == ACTIVE_LINES
//   o_frame_start       1-clk pulse when the counters wrap to (0,0)
//   o_hsync, o_vsync    sync at the configured polarity
//   o_border, o_blank   inside the border / outside the visible area

module ms_video_timing_gen #(
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_BLANK      = 640,
    parameter int unsigned H_SYNC_S     = 656,
    parameter int unsigned H_SYNC_E     = 752,
    parameter int unsigned V_TOTAL      = 524,
    parameter int unsigned V_BLANK      = 480,
    parameter int unsigned V_SYNC_S     = 490,
    parameter int unsigned V_SYNC_E     = 492,
    parameter int unsigned H_DIV        = 2,
    parameter int unsigned V_DIV        = 2,
    parameter int unsigned BORDER_L     = 32,
    parameter int unsigned BORDER_R     = 32,
    parameter int unsigned BORDER_T     = 24,
    parameter int unsigned BORDER_B     = 24,
    parameter int unsigned LEFT_COL_W   = 8,
    parameter int unsigned ACTIVE_LINES = 192,
    parameter int unsigned RENDER_LEAD  = 2,
    parameter logic        HSYNC_POL    = 1'b0,
    parameter logic        VSYNC_POL    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_left_col_blank,
    input  logic [7:0] i_irq_line,
    input  logic       i_hlatch_strobe,
    output logic [7:0] o_hpos,
    output logic [7:0] o_vpos,
    output logic [7:0] o_hlatch_value,
    output logic [7:0] o_render_line,
    output logic       o_render_start,
    output logic       o_next_line,
    output logic       o_line_irq_pulse,
    output logic       o_vblank_irq_pulse,
    output logic       o_frame_start,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_border,
    output logic       o_blank
);

    localparam int unsigned HCW  = $clog2(H_TOTAL);
    localparam int unsigned VCW  = $clog2(V_TOTAL);
    // Repeat factors are 1 or 2, so the logical position is a plain shift
    localparam int unsigned H_SH = (H_DIV == 2) ? 1 : 0;
    localparam int unsigned V_SH = (V_DIV == 2) ? 1 : 0;

    localparam logic [HCW-1:0] C_H_LAST       = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] C_H_BLANK      = HCW'(H_BLANK);
    localparam logic [HCW-1:0] C_H_SYNC_S     = HCW'(H_SYNC_S);
    localparam logic [HCW-1:0] C_H_SYNC_E     = HCW'(H_SYNC_E);
    localparam logic [HCW-1:0] C_LH_ACT_S     = HCW'(BORDER_L);
    localparam logic [HCW-1:0] C_LH_ACT_S_LCB = HCW'(BORDER_L + LEFT_COL_W);
    localparam logic [HCW-1:0] C_LH_ACT_E     = HCW'((H_BLANK >> H_SH) - BORDER_R);

    localparam logic [VCW-1:0] C_V_LAST       = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] C_V_BLANK      = VCW'(V_BLANK);
    localparam logic [VCW-1:0] C_V_SYNC_S     = VCW'(V_SYNC_S);
    localparam logic [VCW-1:0] C_V_SYNC_E     = VCW'(V_SYNC_E);
    localparam logic [VCW-1:0] C_LV_ACT_S     = VCW'(BORDER_T);
    localparam logic [VCW-1:0] C_LV_ACT_E     = VCW'((V_BLANK >> V_SH) - BORDER_B);

    localparam logic [7:0]     C_BORDER_L     = 8'(BORDER_L);
    localparam logic [7:0]     C_BORDER_T     = 8'(BORDER_T);
    localparam logic [7:0]     C_ACTIVE       = 8'(ACTIVE_LINES);
    localparam logic [7:0]     C_LEAD         = 8'(RENDER_LEAD);

    logic [HCW-1:0] r_hcnt;
    logic [VCW-1:0] r_vcnt;

    logic [HCW-1:0] w_lh;
    logic [VCW-1:0] w_lv;
    logic [HCW-1:0] w_lh_start;
    logic           w_h_last;
    logic           w_v_grp_last;
    logic           w_next_line;
    logic           w_frame_wrap;
    logic           w_blank;
    logic           w_hactive;
    logic           w_vactive;
    logic           w_border;
    logic [7:0]     w_hpos;
    logic [7:0]     w_vpos;
    logic           w_hsync;
    logic           w_vsync;

    logic [7:0]     r_hpos;
    logic [7:0]     r_vpos;
    logic [7:0]     r_render_line;
    logic           r_render_start;
    logic           r_next_line;
    logic           r_line_irq;
    logic           r_vblank_irq;
    logic           r_frame_start;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_border;
    logic           r_blank;

    // Native raster counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == C_V_LAST) ? '0 : r_vcnt + VCW'(1);
        end else begin
            r_hcnt <= r_hcnt + HCW'(1);
        end
    end

    // Decode of the current counter position
    assign w_lh         = r_hcnt >> H_SH;
    assign w_lv         = r_vcnt >> V_SH;
    assign w_h_last     = (r_hcnt == C_H_LAST);
    // Last native line of a V_DIV group: every line when V_DIV is 1, odd lines when 2
    assign w_v_grp_last = (V_SH == 0) || r_vcnt[0];
    assign w_next_line  = w_h_last && w_v_grp_last;
    assign w_frame_wrap = w_h_last && (r_vcnt == C_V_LAST);

    assign w_blank      = (r_hcnt >= C_H_BLANK) || (r_vcnt >= C_V_BLANK);
    // The extra left column only masks output; hpos keeps its BORDER_L origin
    assign w_lh_start   = i_left_col_blank ? C_LH_ACT_S_LCB : C_LH_ACT_S;
    assign w_hactive    = !w_blank && (w_lh >= w_lh_start) && (w_lh < C_LH_ACT_E);
    assign w_vactive    = (w_lv >= C_LV_ACT_S) && (w_lv < C_LV_ACT_E);
    assign w_border     = !w_blank && !(w_hactive && w_vactive);

    assign w_hpos       = w_hactive ? (8'(w_lh) - C_BORDER_L) : 8'd0;
    assign w_vpos       = 8'(w_lv) - C_BORDER_T;

    assign w_hsync      = ((r_hcnt >= C_H_SYNC_S) && (r_hcnt < C_H_SYNC_E)) ? HSYNC_POL : ~HSYNC_POL;
    assign w_vsync      = ((r_vcnt >= C_V_SYNC_S) && (r_vcnt < C_V_SYNC_E)) ? VSYNC_POL : ~VSYNC_POL;

    // Registered outputs; reset also discards any pulse due in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hpos         <= 8'd0;
            r_vpos         <= 8'd0;
            r_render_line  <= 8'd0;
            r_render_start <= 1'b0;
            r_next_line    <= 1'b0;
            r_line_irq     <= 1'b0;
            r_vblank_irq   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_hsync        <= ~HSYNC_POL;
            r_vsync        <= ~VSYNC_POL;
            r_border       <= 1'b0;
            r_blank        <= 1'b1;
        end else begin
            r_hpos         <= w_hpos;
            r_vpos         <= w_vpos;
            r_next_line    <= w_next_line;
            r_line_irq     <= w_next_line && (w_vpos == i_irq_line);
            r_vblank_irq   <= w_next_line && (w_vpos == C_ACTIVE);
            r_frame_start  <= w_frame_wrap;
            r_hsync        <= w_hsync;
            r_vsync        <= w_vsync;
            r_border       <= w_border;
            r_blank        <= w_blank;
            if (w_next_line) begin
                r_render_line <= w_vpos + C_LEAD;
            end
            // Follows next_line by one clock, once render_line holds the new value
            r_render_start <= r_next_line && (r_render_line <= C_ACTIVE);
        end
    end

`ifdef VDP_HLATCH_EN
    logic r_hl_s1;
    logic r_hl_s2;
    logic r_hl_s3;
    logic [7:0] r_hlatch;
    logic w_hl_edge;

    assign w_hl_edge = r_hl_s2 && !r_hl_s3;

    // Two-flop synchroniser, rising-edge detect, then capture of registered hpos
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hl_s1  <= 1'b0;
            r_hl_s2  <= 1'b0;
            r_hl_s3  <= 1'b0;
            r_hlatch <= 8'd0;
        end else begin
            r_hl_s1 <= i_hlatch_strobe;
            r_hl_s2 <= r_hl_s1;
            r_hl_s3 <= r_hl_s2;
            if (w_hl_edge) begin
                r_hlatch <= r_hpos;
            end
        end
    end

    assign o_hlatch_value = r_hlatch;
`else
    logic w_unused_strobe;
    assign w_unused_strobe = i_hlatch_strobe;
    assign o_hlatch_value  = 8'd0;
`endif

    assign o_hpos             = r_hpos;
    assign o_vpos             = r_vpos;
    assign o_render_line      = r_render_line;
    assign o_render_start     = r_render_start;
    assign o_next_line        = r_next_line;
    assign o_line_irq_pulse   = r_line_irq;
    assign o_vblank_irq_pulse = r_vblank_irq;
    assign o_frame_start      = r_frame_start;
    assign o_hsync            = r_hsync;
    assign o_vsync            = r_vsync;
    assign o_border           = r_border;
    assign o_blank            = r_blank;

endmodule
